// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - two-requester (fetch/data) arbiter onto a single memory port with timeout
module cpu_mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_done,
   output logic        i_err,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_done,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nx;
   owner_t      owner, last_owner, grant;
   logic        grant_en;
   logic        done, err;
   logic [7:0]  cnt;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  wstrb_q;

   // Arbitration in IDLE, completion/timeout detection in BUSY, owner-gated handshake outputs
   always_comb begin
      state_nx = state;
      grant_en = 1'b0;
      grant    = OWN_I;
      done     = 1'b0;
      err      = 1'b0;
      case (state)
         IDLE: begin
            if (i_req && d_req) begin
               grant_en = 1'b1;
               // Ties go to whoever did not win last time
               grant    = (last_owner == OWN_I) ? OWN_D : OWN_I;
            end else if (i_req) begin
               grant_en = 1'b1;
               grant    = OWN_I;
            end else if (d_req) begin
               grant_en = 1'b1;
               grant    = OWN_D;
            end
            if (grant_en) state_nx = BUSY;
         end
         BUSY: begin
            // A ready on the final timeout cycle still counts as a normal completion
            if (mem_ready) begin
               done     = 1'b1;
               state_nx = IDLE;
            end else if (cnt == TO_LAST) begin
               done     = 1'b1;
               err      = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase

      i_done    = done && (owner == OWN_I);
      i_err     = err  && (owner == OWN_I);
      d_done    = done && (owner == OWN_D);
      d_err     = err  && (owner == OWN_D);
      i_rdata   = i_done ? mem_rdata : 32'h0;
      d_rdata   = d_done ? mem_rdata : 32'h0;
      mem_valid = (state == BUSY);
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_wstrb = wstrb_q;
   end

   // State register plus captured request copy and wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= OWN_I;
         last_owner <= OWN_I;
         cnt        <= 8'h0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'h0;
      end else begin
         state <= state_nx;
         if (grant_en) begin
            owner      <= grant;
            last_owner <= grant;
            cnt        <= 8'h0;
            if (grant == OWN_D) begin
               addr_q  <= d_addr;
               wdata_q <= d_wdata;
               wstrb_q <= d_wstrb;
            end else begin
               addr_q  <= i_addr;
               wdata_q <= 32'h0;
               wstrb_q <= 4'h0;
            end
         end else if (state == BUSY && !mem_ready) begin
            cnt <= cnt + 8'h1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - scoreboard bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_done, i_err;
   logic [31:0] i_rdata;
   logic        d_req;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_done, d_err;
   logic [31:0] d_rdata;
   logic        mem_valid;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   typedef struct {
      logic        is_d;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] rdata;
      logic        err;
      int          cycles;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   cpu_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_err(i_err), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic is_d, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic [31:0] rdata, input logic err,
                               input int cycles);
      exp_t e;
      e.is_d = is_d; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
      e.rdata = rdata; e.err = err; e.cycles = cycles;
      return e;
   endfunction

   // Memory responder for one BUSY period; compares bus and done against the scoreboard head
   task automatic serve(input int ready_at, input logic [31:0] rdata_val, input bit perturb);
      exp_t        e;
      bit          got;
      logic        own_done, own_err, other;
      logic [31:0] own_rdata;
      got = 0;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL serve_no_expectation: scoreboard empty, required one entry");
         return;
      end
      e = sb[0];
      for (int k = 0; k < 12 && !got; k++) begin
         @(negedge clk);
         mem_ready = (k == ready_at);
         mem_rdata = (k == ready_at) ? rdata_val : $urandom();
         if (perturb && k > 0) begin
            i_addr = $urandom(); d_addr = $urandom(); d_wdata = $urandom();
         end
         #1;
         checks++;
         if (mem_valid !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.wdata || mem_wstrb !== e.wstrb) begin
            errors++;
            $display("FAIL mem_bus cyc%0d: got v=%b a=%h w=%h s=%b required v=1 a=%h w=%h s=%b",
                     k, mem_valid, mem_addr, mem_wdata, mem_wstrb, e.addr, e.wdata, e.wstrb);
         end
         own_done  = e.is_d ? d_done  : i_done;
         own_err   = e.is_d ? d_err   : i_err;
         own_rdata = e.is_d ? d_rdata : i_rdata;
         other     = e.is_d ? (i_done | i_err | (|i_rdata)) : (d_done | d_err | (|d_rdata));
         checks++;
         if (other !== 1'b0) begin
            errors++;
            $display("FAIL non_owner_quiet cyc%0d: got %b required 0", k, other);
         end
         if (own_done === 1'b1) begin
            got = 1;
            void'(sb.pop_front());
            checks++;
            if (own_err !== e.err || (!e.err && own_rdata !== e.rdata) || (k + 1) != e.cycles) begin
               errors++;
               $display("FAIL done: got err=%b rdata=%h cycles=%0d required err=%b rdata=%h cycles=%0d",
                        own_err, own_rdata, k + 1, e.err, e.rdata, e.cycles);
            end
         end else begin
            checks++;
            if (own_err !== 1'b0 || own_rdata !== 32'h0) begin
               errors++;
               $display("FAIL owner_pending cyc%0d: got err=%b rdata=%h required 0/0", k, own_err, own_rdata);
            end
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL done_timeout: no done within 12 cycles, required done at cycle %0d", e.cycles);
      end
   endtask

   // One IDLE cycle: set the requests for this cycle and confirm the port is quiet
   task automatic idle_step(input logic ni, input logic nd);
      @(negedge clk);
      i_req = ni; d_req = nd; mem_ready = 1'b0;
      #1;
      checks++;
      if (mem_valid !== 1'b0 || i_done !== 1'b0 || d_done !== 1'b0 || i_err !== 1'b0 || d_err !== 1'b0) begin
         errors++;
         $display("FAIL idle_quiet: got v=%b id=%b dd=%b ie=%b de=%b required all 0",
                  mem_valid, i_done, d_done, i_err, d_err);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; i_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
      i_addr = 32'h1234_5678; d_addr = 32'h9abc_def0; d_wdata = 32'hffff_ffff; d_wstrb = 4'hf;
      mem_rdata = 32'h5555_aaaa;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({mem_valid, i_done, i_err, d_done, d_err} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
          mem_wstrb !== 4'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got v=%b a=%h w=%h s=%b ir=%h dr=%h required all 0",
                  mem_valid, mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata);
      end
      @(negedge clk);
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      idle_step(1'b0, 1'b0);
   endtask

   task automatic test_tie();
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h400;
      d_req = 1'b1; d_addr = 32'h500; d_wdata = 32'h1122_3344; d_wstrb = 4'hf;
      sb.push_back(mk(1'b1, 32'h500, 32'h1122_3344, 4'hf, 32'h0, 1'b0, 1));
      serve(0, 32'h0, 1'b0);
      idle_step(1'b1, 1'b0);
      sb.push_back(mk(1'b0, 32'h400, 32'h0, 4'h0, 32'hcafe_0001, 1'b0, 2));
      serve(1, 32'hcafe_0001, 1'b0);
      d_addr = 32'h504; d_wdata = 32'h0; d_wstrb = 4'h0;
      idle_step(1'b1, 1'b1);
      sb.push_back(mk(1'b1, 32'h504, 32'h0, 4'h0, 32'hbeef_0002, 1'b0, 1));
      serve(0, 32'hbeef_0002, 1'b0);
      idle_step(1'b0, 1'b0);
   endtask

   task automatic test_fetch();
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h100;
      sb.push_back(mk(1'b0, 32'h100, 32'h0, 4'h0, 32'h0000_0013, 1'b0, 1));
      serve(0, 32'h0000_0013, 1'b0);
      idle_step(1'b0, 1'b0);
   endtask

   task automatic test_store();
      @(negedge clk);
      d_req = 1'b1; d_addr = 32'h2000; d_wdata = 32'hdead_beef; d_wstrb = 4'b0011;
      sb.push_back(mk(1'b1, 32'h2000, 32'hdead_beef, 4'b0011, 32'h0, 1'b0, 4));
      serve(3, 32'h0, 1'b1);
      idle_step(1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      @(negedge clk);
      d_req = 1'b1; d_addr = 32'h300; d_wdata = 32'h0; d_wstrb = 4'h0;
      sb.push_back(mk(1'b1, 32'h300, 32'h0, 4'h0, 32'h0, 1'b1, 4));
      serve(-1, 32'h0, 1'b0);
      idle_step(1'b0, 1'b0);
      @(negedge clk);
      d_req = 1'b1; d_addr = 32'h304;
      sb.push_back(mk(1'b1, 32'h304, 32'h0, 4'h0, 32'h7777_8888, 1'b0, 4));
      serve(3, 32'h7777_8888, 1'b0);
      idle_step(1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h800;
      sb.push_back(mk(1'b0, 32'h800, 32'h0, 4'h0, 32'h0000_0a0a, 1'b0, 1));
      serve(0, 32'h0000_0a0a, 1'b0);
      idle_step(1'b1, 1'b0);
      sb.push_back(mk(1'b0, 32'h800, 32'h0, 4'h0, 32'h0000_0b0b, 1'b0, 3));
      serve(2, 32'h0000_0b0b, 1'b0);
      idle_step(1'b0, 1'b0);
   endtask

   task automatic test_reset_busy();
      @(negedge clk);
      d_req = 1'b1; d_addr = 32'h600; d_wdata = 32'h0; d_wstrb = 4'h0;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h600) begin
         errors++;
         $display("FAIL rst_busy_first: got v=%b a=%h required v=1 a=00000600", mem_valid, mem_addr);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (mem_valid !== 1'b1 || d_done !== 1'b0 || i_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy_second: got v=%b dd=%b id=%b required 1/0/0", mem_valid, d_done, i_done);
      end
      @(negedge clk);
      rst = 1'b0; d_req = 1'b0;
      #1;
      checks++;
      if (mem_valid !== 1'b0 || d_done !== 1'b0 || i_done !== 1'b0 || mem_addr !== 32'h0 || mem_wstrb !== 4'h0) begin
         errors++;
         $display("FAIL rst_busy_after: got v=%b dd=%b id=%b a=%h s=%b required all 0",
                  mem_valid, d_done, i_done, mem_addr, mem_wstrb);
      end
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h700;
      d_req = 1'b1; d_addr = 32'h604; d_wdata = 32'h0000_00ab; d_wstrb = 4'b0001;
      sb.push_back(mk(1'b1, 32'h604, 32'h0000_00ab, 4'b0001, 32'h0, 1'b0, 1));
      serve(0, 32'h0, 1'b0);
      idle_step(1'b1, 1'b0);
      sb.push_back(mk(1'b0, 32'h700, 32'h0, 4'h0, 32'h0000_0c0c, 1'b0, 1));
      serve(0, 32'h0000_0c0c, 1'b0);
      idle_step(1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_tie();
      test_fetch();
      test_store();
      test_timeout();
      test_back_to_back();
      test_reset_busy();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries left required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_mem_arbiter.md
CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, range 2..255: number of BUSY cycles without mem_ready before a bus error.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i_req  input  1  instruction-fetch request; held high until i_done.
REQ-005 SHALL have port i_addr  input  32  fetch address; stable while i_req is high.
REQ-006 SHALL have port i_done  output  1  fetch completes this cycle.
REQ-007 SHALL have port i_err  output  1  fetch ended by timeout; valid only with i_done.
REQ-008 SHALL have port i_rdata  output  32  fetched word; valid only with i_done.
REQ-009 SHALL have port d_req  input  1  load/store request; held high until d_done.
REQ-010 SHALL have port d_addr  input  32  data address; stable while d_req is high.
REQ-011 SHALL have port d_wdata  input  32  store data.
REQ-012 SHALL have port d_wstrb  input  4  byte enables (0001/0011/1111 for store, 0000 for load).
REQ-013 SHALL have port d_done  output  1  data access completes this cycle.
REQ-014 SHALL have port d_err  output  1  data access ended by timeout; valid only with d_done.
REQ-015 SHALL have port d_rdata  output  32  load word; valid only with d_done.
REQ-016 SHALL have port mem_valid  output  1  memory request valid.
REQ-017 SHALL have port mem_addr  output  32  memory address.
REQ-018 SHALL have port mem_wdata  output  32  memory write data.
REQ-019 SHALL have port mem_wstrb  output  4  memory byte enables; 0000 means read.
REQ-020 SHALL have port mem_ready  input  1  memory accepts/completes the request this cycle.
REQ-021 SHALL have port mem_rdata  input  32  memory read data, valid with mem_ready.

Function
REQ-022 SHALL implement states IDLE and BUSY, plus an owner register (I or D) and a last_owner register.
REQ-023 IDLE: only i_req set -> grant I; only d_req set -> grant D; both set -> grant the requester that is not last_owner; neither set -> stay IDLE.
REQ-024 On grant, SHALL register the owner's address, wdata and wstrb (I: wstrb 0000, wdata 0), clear the timeout counter, set last_owner to the granted requester, and enter BUSY on the next cycle.
REQ-025 mem_valid SHALL be 1 exactly in BUSY; mem_addr/mem_wdata/mem_wstrb SHALL come from the registered copy and stay constant for the whole BUSY period.
REQ-026 In BUSY with mem_ready=1, SHALL assert the owner's done for that cycle only, with err=0, and drive its rdata from mem_rdata combinationally; next state IDLE.
REQ-027 In BUSY with mem_ready=0, SHALL increment the 8-bit counter; when the counter equals TIMEOUT_CYCLES-1, SHALL assert the owner's done and err that cycle and go to IDLE.
REQ-028 mem_ready together with the timeout cycle SHALL count as normal completion (err=0).
REQ-029 Non-owner done/err SHALL be 0; rdata outputs SHALL be 0 whenever the matching done is 0.
REQ-030 Minimum transaction: request cycle N, mem_valid at N+1, done at N+1 if ready; the next grant is evaluated in IDLE at N+2.
REQ-031 The arbiter SHALL NOT evaluate requests in BUSY; requester inputs changing during BUSY SHALL have no effect on mem_* outputs.
REQ-032 Requesters drop req in the cycle after done; a req still high in the following IDLE cycle SHALL be treated as a new request.

Reset
REQ-033 When rst=1 at a clock edge: state IDLE, counter 0, owner I, last_owner I (so the first tie grants D), registered addr/wdata/wstrb 0.
REQ-034 During and after reset: mem_valid, i_done, i_err, d_done, d_err 0; mem_addr, mem_wdata, mem_wstrb, i_rdata, d_rdata 0.
REQ-035 Reset during BUSY SHALL abandon the transaction with no done pulse to either requester.

Verification
REQ-036 Single fetch: i_req, i_addr=0x100, mem_ready on 1st BUSY cycle with rdata=0x00000013 -> mem_valid 1 cycle, mem_wstrb=0000, i_done=1, i_rdata=0x13, i_err=0.
REQ-037 Store: d_req, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0011, ready after 3 wait cycles -> mem_* stable for 4 cycles, d_done on 4th cycle, i_done 0 throughout.
REQ-038 Tie after reset: i_req and d_req both high -> D served first, then I granted in the next IDLE cycle; a subsequent tie grants D again (alternation).
REQ-039 Timeout with TIMEOUT_CYCLES=4, mem_ready stuck 0 on a load -> mem_valid exactly 4 cycles, d_done=1 and d_err=1 on the 4th, then IDLE; ready on the 4th cycle instead -> d_err=0.
REQ-040 Reset mid-BUSY: assert rst on 2nd BUSY cycle -> mem_valid 0 next cycle, no done pulse, first tie after release grants D.
